// File: rtl/tick_scheduler.sv
// Frame tick generator with a speed-adjustable divider and a four-phase
// frame sequencer (IDLE -> ERASE -> MOVE -> DRAW) driven by datapath strobes.
module tick_scheduler #(
    parameter int CNT_W       = 27,
    parameter int BASE_PERIOD = 833332,
    parameter int STEP        = 50000,
    parameter int MIN_PERIOD  = 200000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             enable,
    input  logic             speed_up,
    input  logic             phase_done,
    output logic             tick,
    output logic             phase_start,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       frame_count,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        MOVE  = 2'd2,
        DRAW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    // One extra bit so the floor comparison cannot wrap for large STEP/MIN.
    localparam logic [CNT_W:0]   FLOOR_C = {1'b0, MIN_C} + {1'b0, STEP_C};

    logic [CNT_W-1:0] counter_reg, counter_next;
    logic [CNT_W-1:0] period_reg, period_next;
    state_t           state_reg, state_next;
    logic             phase_start_reg, phase_start_next;
    logic [7:0]       frame_count_reg, frame_count_next;
    logic             overrun_reg, overrun_next;
    logic             done_ok;

    assign tick        = enable && (counter_reg >= period_reg);
    assign phase       = state_reg;
    assign phase_start = phase_start_reg;
    assign period      = period_reg;
    assign frame_count = frame_count_reg;
    assign overrun     = overrun_reg;

    // Divider and period
    always_comb begin
        counter_next = counter_reg;
        period_next  = period_reg;
        if (enable) begin
            counter_next = tick ? '0 : counter_reg + ONE_C;
        end
        if (speed_up) begin
            period_next = ({1'b0, period_reg} >= FLOOR_C) ? period_reg - STEP_C : MIN_C;
        end
    end

    // A strobe on the launch cycle belongs to the previous phase, so it is ignored.
    assign done_ok = phase_done && !phase_start_reg;

    always_comb begin
        state_next       = state_reg;
        phase_start_next = 1'b0;
        frame_count_next = frame_count_reg;
        overrun_next     = overrun_reg;
        case (state_reg)
            IDLE: begin
                if (tick) begin
                    state_next       = ERASE;
                    phase_start_next = 1'b1;
                end
            end
            ERASE: begin
                if (done_ok) begin
                    state_next       = MOVE;
                    phase_start_next = 1'b1;
                end
                if (tick) overrun_next = 1'b1;
            end
            MOVE: begin
                if (done_ok) begin
                    state_next       = DRAW;
                    phase_start_next = 1'b1;
                end
                if (tick) overrun_next = 1'b1;
            end
            DRAW: begin
                if (done_ok) begin
                    frame_count_next = frame_count_reg + 8'd1;
                    if (tick) begin
                        // Frame finished just in time: chain straight into the next one.
                        state_next       = ERASE;
                        phase_start_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (tick) begin
                    overrun_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            counter_reg     <= '0;
            period_reg      <= BASE_C;
            state_reg       <= IDLE;
            phase_start_reg <= 1'b0;
            frame_count_reg <= 8'd0;
            overrun_reg     <= 1'b0;
        end else begin
            counter_reg     <= counter_next;
            period_reg      <= period_next;
            state_reg       <= state_next;
            phase_start_reg <= phase_start_next;
            frame_count_reg <= frame_count_next;
            overrun_reg     <= overrun_next;
        end
    end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 The block SHALL provide parameter CNT_W, default 27, width of divider counter and period.
REQ-002 The block SHALL provide parameter BASE_PERIOD, default 833332, reset terminal count (60 Hz frame tick at 50 MHz).
REQ-003 The block SHALL provide parameter STEP, default 50000, period decrement per speed_up.
REQ-004 The block SHALL provide parameter MIN_PERIOD, default 200000, floor on period.
REQ-005 The block SHALL have one clock, CLOCK_50, and an asynchronous active-high reset, reset.
REQ-006 The block SHALL have these ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  run (1) or pause (0) of the divider.
- speed_up  in  1  one-cycle request to shorten the period.
- phase_done  in  1  datapath completion strobe for the current phase.
- tick  out  1  one-cycle pulse at each divider wrap.
- phase_start  out  1  one-cycle pulse launching a datapath phase.
- phase  out  2  current phase: 0 IDLE, 1 ERASE, 2 MOVE, 3 DRAW.
- period  out  CNT_W  current terminal count.
- frame_count  out  8  completed frames, wraps 255->0.
- overrun  out  1  sticky: a tick arrived while a frame was in progress.

Function
REQ-007 The divider SHALL increment by 1 per cycle while enable=1 and hold while enable=0.
REQ-008 When enable=1 and counter>=period, the divider SHALL load 0 and assert tick for that cycle only, giving a period+1 cycle tick interval.
REQ-009 On speed_up=1, period SHALL become max(period-STEP, MIN_PERIOD) on the next edge, computed without underflow. Speed_up at the floor SHALL leave period unchanged.
REQ-010 A period change SHALL take effect immediately. A counter already above the new period SHALL wrap on the next enabled cycle, per REQ-008.
REQ-011 The FSM SHALL have states IDLE, ERASE, MOVE and DRAW, encoded on phase as in REQ-006, all registered.
REQ-012 In IDLE, a tick SHALL move the FSM to ERASE on the next edge.
REQ-013 On the first cycle in each of ERASE, MOVE and DRAW, phase_start SHALL be 1. On all other cycles it SHALL be 0.
REQ-014 phase_done SHALL be ignored on the phase_start cycle. It SHALL be accepted on any later cycle of the phase.
REQ-015 Accepted phase_done SHALL advance the FSM ERASE->MOVE, MOVE->DRAW and DRAW->IDLE.
REQ-016 On DRAW->IDLE, frame_count SHALL increment by 1 modulo 256.
REQ-017 If a tick and an accepted phase_done in DRAW occur in the same cycle:
- the FSM SHALL go directly to ERASE;
- frame_count SHALL increment;
- overrun SHALL NOT be set.
REQ-018 Any other tick while the FSM is not IDLE SHALL set overrun and SHALL be dropped, not queued.
REQ-019 phase_done while in IDLE SHALL be ignored.
REQ-020 enable=0 SHALL NOT stall an in-progress frame. Only tick generation pauses.
REQ-021 Once set, overrun SHALL remain 1 until reset.

Reset
REQ-022 On reset=1, asynchronously:
- counter SHALL be 0 and period SHALL be BASE_PERIOD;
- the FSM SHALL be in IDLE;
- tick, phase_start, phase, frame_count and overrun SHALL be 0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame without incrementing frame_count.
REQ-024 After deassertion, the first tick SHALL occur BASE_PERIOD+1 enabled cycles later.

Verification
REQ-025 The bench SHALL use parameters BASE_PERIOD=9, STEP=2, MIN_PERIOD=3, CNT_W=4 and cover these scenarios:
- Hold enable=1 after reset, no phase_done -> tick on enabled cycles 10, 20 and 30; overrun=1 after the second tick.
- Tick in IDLE, then phase_done 2 cycles after each phase_start -> phase sequence 1,2,3,0; three phase_start pulses; frame_count=1.
- Three speed_up pulses -> period 7, 5, 3. A fourth pulse -> period stays 3. Counter at 8 when period drops to 5 -> tick on the next cycle.
- Hold phase_done=1 continuously -> each phase lasts exactly 2 cycles; the start-cycle done is ignored.
- Drive tick and DRAW-done in the same cycle -> phase goes 3->1 with phase_start; frame_count increments; overrun=0.
- Assert reset while in MOVE with frame_count=5 -> phase=0, frame_count=0, period=9, no tick for 10 cycles.
